// File: rtl/spi_slave_pkg.sv
// Shared state, command and frame-width definitions for the SPI slave front-end.
// Defining SPI_SLAVE_PARITY_EN adds one even-parity bit to every RX and TX frame.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHK_CMD  = 3'd1,
    ST_RX       = 3'd2,
    ST_TX_WAIT  = 3'd3,
    ST_TX_SHIFT = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

`ifdef SPI_SLAVE_PARITY_EN
  localparam int unsigned PAR_BITS = 32'd1;
`else
  localparam int unsigned PAR_BITS = 32'd0;
`endif

  // Bits captured on MOSI per frame: command, payload and optional parity.
  function automatic int unsigned frame_bits(input int unsigned data_w);
    return data_w + 32'd2 + PAR_BITS;
  endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// MSB-first parallel-to-serial shifter for RAM read data, with optional trailing parity.
// The parity bit is appended only when SPI_SLAVE_PARITY_EN is defined.
module spi_tx_shifter
  import spi_slave_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] data_in,
  output logic              bit_out,
  output logic              done
);

  localparam int unsigned TXW = DATA_W + PAR_BITS;
  localparam int unsigned CW  = $clog2(TXW + 1);
  localparam logic [CW-1:0] LOAD_CNT = CW'(TXW - 1);

  logic [TXW-1:0] sreg_q, sreg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           bit_q, bit_d;
  logic [TXW-1:0] load_word_s;

`ifdef SPI_SLAVE_PARITY_EN
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
  assign load_word_s = {data_in, even_parity(data_in)};
`else
  assign load_word_s = data_in;
`endif

  // cnt_q counts bits still to be driven after the one currently on the line.
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    if (clr) begin
      sreg_d = '0;
      cnt_d  = '0;
      bit_d  = 1'b0;
    end else if (load) begin
      sreg_d = load_word_s << 1;
      cnt_d  = LOAD_CNT;
      bit_d  = load_word_s[TXW-1];
    end else if (shift_en) begin
      if (cnt_q == '0) begin
        sreg_d = '0;
        bit_d  = 1'b0;
      end else begin
        sreg_d = sreg_q << 1;
        cnt_d  = cnt_q - CW'(1);
        bit_d  = sreg_q[TXW-1];
      end
    end else begin
      bit_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      bit_q  <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
    end
  end

  assign bit_out = bit_q;
  assign done    = shift_en & (cnt_q == '0);

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end: receives one {cmd, payload} frame per SS_n low period and
// returns RAM read data on MISO. SPI_SLAVE_PARITY_EN enables frame parity.
module spi_slave_ctrl
  import spi_slave_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned TX_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              busy,
  output logic              err
);

  localparam int unsigned FW  = DATA_W + 2;
  localparam int unsigned FWT = frame_bits(DATA_W);
  localparam int unsigned CW  = $clog2(FWT + 1);
  localparam int unsigned WW  = $clog2(TX_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(FWT - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TX_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [FWT-2:0]  sh_q, sh_d;
  logic [CW-1:0]   bcnt_q, bcnt_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic            seen_q, seen_d;
  logic [FW-1:0]   rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;

  logic [FWT-1:0]  full_s;
  logic [FW-1:0]   frame_s;
  logic            frame_ok_s;
  logic            tx_load_s, tx_shift_s, tx_clr_s, tx_done_s, tx_bit_s;

  assign full_s = {sh_q, MOSI};

`ifdef SPI_SLAVE_PARITY_EN
  function automatic logic parity_ok(input logic [FWT-1:0] f);
    return ~(^f);
  endfunction
  assign frame_s    = full_s[FWT-1:1];
  assign frame_ok_s = parity_ok(full_s);
`else
  assign frame_s    = full_s;
  assign frame_ok_s = 1'b1;
`endif

  // Next-state logic; SS_n high in an active state is an abort and takes priority.
  always_comb begin
    state_d    = state_q;
    sh_d       = '0;
    bcnt_d     = '0;
    wcnt_d     = '0;
    seen_d     = seen_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    err_d      = 1'b0;
    tx_load_s  = 1'b0;
    tx_shift_s = 1'b0;
    tx_clr_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = SS_n ? ST_IDLE : ST_CHK_CMD;
      end
      ST_CHK_CMD: begin
        state_d = SS_n ? ST_IDLE : ST_RX;
      end
      ST_RX: begin
        if (SS_n) begin
          state_d = ST_IDLE;
          err_d   = (bcnt_q != '0);
        end else if (bcnt_q == LAST_BIT) begin
          state_d = ST_DONE;
          if (!frame_ok_s) begin
            err_d = 1'b1;
          end else begin
            rx_data_d  = frame_s;
            rx_valid_d = 1'b1;
            case (frame_s[FW-1:FW-2])
              CMD_RD_ADDR: seen_d = 1'b1;
              CMD_RD_DATA: begin
                if (seen_q) begin
                  seen_d  = 1'b0;
                  state_d = ST_TX_WAIT;
                end else begin
                  err_d = 1'b1;
                end
              end
              CMD_WR_ADDR, CMD_WR_DATA: state_d = ST_DONE;
              default: state_d = ST_DONE;
            endcase
          end
        end else begin
          sh_d   = full_s[FWT-2:0];
          bcnt_d = bcnt_q + CW'(1);
        end
      end
      ST_TX_WAIT: begin
        if (SS_n) begin
          state_d  = ST_IDLE;
          err_d    = 1'b1;
          tx_clr_s = 1'b1;
        end else if (tx_valid) begin
          state_d   = ST_TX_SHIFT;
          tx_load_s = 1'b1;
        end else if (wcnt_q == WAIT_LAST) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      ST_TX_SHIFT: begin
        if (SS_n) begin
          state_d  = ST_IDLE;
          err_d    = 1'b1;
          tx_clr_s = 1'b1;
        end else begin
          tx_shift_s = 1'b1;
          state_d    = tx_done_s ? ST_DONE : ST_TX_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = SS_n ? ST_IDLE : ST_DONE;
      end
      default: begin
        state_d  = ST_IDLE;
        tx_clr_s = 1'b1;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sh_q       <= '0;
      bcnt_q     <= '0;
      wcnt_q     <= '0;
      seen_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      bcnt_q     <= bcnt_d;
      wcnt_q     <= wcnt_d;
      seen_q     <= seen_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  spi_tx_shifter #(
    .DATA_W (DATA_W)
  ) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tx_clr_s),
    .load     (tx_load_s),
    .shift_en (tx_shift_s),
    .data_in  (tx_data),
    .bit_out  (tx_bit_s),
    .done     (tx_done_s)
  );

  assign MISO     = tx_bit_s;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign err      = err_q;
  assign busy     = busy_q;

endmodule
